// File: rtl/sign_abs_to_bipolar.sv
// rtl/sign_abs_to_bipolar.sv - sign/magnitude unary pair to bipolar unary bitstream
// Half-unit credit accumulator plus pending-output counter with valid/ready handshakes on both sides.
module sign_abs_to_bipolar #(
  parameter int DEP = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic sign,
  input  logic abs,
  output logic in_ready,
  output logic drop,
  output logic out_valid,
  output logic bipolar,
  input  logic out_ready
);

  localparam logic [DEP-1:0] PEND_FULL = '1;
  localparam logic [DEP:0]   ONE_UNIT  = (DEP+1)'(2);
  localparam logic [DEP:0]   HALF_UNIT = (DEP+1)'(1);

  logic [DEP-1:0] pend;
  logic [DEP:0]   acc;

  logic           acc_in;
  logic           cons;
  logic           acc_hi;
  logic [DEP:0]   c_add;
  logic [DEP:0]   sub_amt;
  logic [DEP-1:0] pend_inc;
  logic [DEP-1:0] pend_dec;

  assign acc_hi    = (acc >= ONE_UNIT);
  assign in_ready  = (pend != PEND_FULL);
  assign out_valid = (pend != '0);
  assign bipolar   = out_valid & acc_hi;
  assign drop      = in_valid & ~in_ready;

  assign acc_in = in_valid & in_ready;
  assign cons   = out_valid & out_ready;

  assign pend_inc = {{(DEP-1){1'b0}}, acc_in};
  assign pend_dec = {{(DEP-1){1'b0}}, cons};

  // A positive magnitude bit earns a full unit, a negative one nothing, a zero bit half a unit.
  always_comb begin
    c_add = '0;
    if (acc_in) begin
      if (abs) begin
        c_add = sign ? '0 : ONE_UNIT;
      end else begin
        c_add = HALF_UNIT;
      end
    end
  end

  // The emitted bit was decided on the pre-update credit, so retire a full unit only for a 1.
  always_comb begin
    sub_amt = '0;
    if (cons && acc_hi) begin
      sub_amt = ONE_UNIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      acc  <= '0;
    end else begin
      pend <= pend + pend_inc - pend_dec;
      acc  <= acc + c_add - sub_amt;
    end
  end

endmodule

// File: tb/tb_sign_abs_to_bipolar.sv
// tb/tb_sign_abs_to_bipolar.sv - self-checking bench for sign_abs_to_bipolar
// Directed vectors; a credit/count model checks every cycle, literal checks pin the model.
module tb_sign_abs_to_bipolar;

  localparam int DEP  = 3;
  localparam int FULL = (1 << DEP) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic sign = 1'b0;
  logic abs = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, drop, out_valid, bipolar;

  int checks = 0;
  int failures = 0;

  // Model state: totals since reset, from which queue depth and credit follow.
  int m_accepted = 0;
  int m_consumed = 0;
  int m_credit_in = 0;
  int m_ones = 0;

  sign_abs_to_bipolar #(.DEP(DEP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .sign(sign),
    .abs(abs),
    .in_ready(in_ready),
    .drop(drop),
    .out_valid(out_valid),
    .bipolar(bipolar),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge rst_n) begin
    m_accepted  = 0;
    m_consumed  = 0;
    m_credit_in = 0;
    m_ones      = 0;
  end

  // Inputs only change just after posedge, so at negedge they are what the next edge will see.
  always @(negedge clk) begin
    int pend_m, credit_m;
    bit ov_m, bp_m, ir_m, drop_m;
    pend_m   = m_accepted - m_consumed;
    credit_m = m_credit_in - 2 * m_ones;
    ov_m     = (pend_m > 0);
    bp_m     = ov_m && (credit_m >= 2);
    ir_m     = (pend_m < FULL);
    drop_m   = in_valid && !ir_m;
    chk("model_out_valid", int'(out_valid), int'(ov_m));
    chk("model_bipolar", int'(bipolar), int'(bp_m));
    chk("model_in_ready", int'(in_ready), int'(ir_m));
    chk("model_drop", int'(drop), int'(drop_m));
    chk("model_pend", int'(dut.pend), pend_m);
    chk("model_acc", int'(dut.acc), credit_m);
    checks++;
    if (int'(dut.acc) > 2 * int'(dut.pend) + 1) begin
      failures++;
      $display("FAIL invariant: acc %0d exceeds 2*pend+1 with pend %0d", dut.acc, dut.pend);
    end
    if (rst_n) begin
      if (in_valid && ir_m) begin
        m_accepted++;
        m_credit_in += abs ? (sign ? 0 : 2) : 1;
      end
      if (ov_m && out_ready) begin
        m_consumed++;
        if (bp_m) m_ones++;
      end
    end
  end

  // Apply one cycle of inputs, sample outputs mid-cycle, then advance past the next edge.
  task automatic step(input bit iv, input bit s, input bit a, input bit ordy,
                      output bit ov, output bit bp, output bit ir, output bit dr);
    in_valid  = iv;
    sign      = s;
    abs       = a;
    out_ready = ordy;
    #2;
    ov = out_valid;
    bp = bipolar;
    ir = in_ready;
    dr = drop;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit ov, bp, ir, dr;
    int ones, outs;
    bit seq_s[4];
    bit seq_a[4];
    seq_a = '{1'b1, 1'b0, 1'b1, 1'b0};
    seq_s = '{1'b0, 1'b0, 1'b1, 1'b1};

    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_bipolar", int'(bipolar), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_drop", int'(drop), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Constant +1: one bit in flight, all ones.
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1, 1, ov, bp, ir, dr);
      chk("pos_out_valid", int'(ov), (i > 0) ? 1 : 0);
      chk("pos_bipolar", int'(bp), (i > 0) ? 1 : 0);
      if (i > 0) chk("pos_pend", int'(dut.pend), 1);
    end

    // Constant -1: all zeros, no credit ever held.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 1, 1, ov, bp, ir, dr);
      chk("neg_out_valid", int'(ov), (i > 0) ? 1 : 0);
      chk("neg_bipolar", int'(bp), 0);
      chk("neg_acc", int'(dut.acc), 0);
    end

    // Zero magnitude alternates 0,1,0,1 from the first output.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 1, ov, bp, ir, dr);
      if (i > 0) chk("zero_bipolar", int'(bp), (i % 2 == 0) ? 1 : 0);
    end

    // Mixed pattern averages to zero: 8 ones in 16 outputs.
    do_reset();
    ones = 0;
    outs = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) step(1, seq_s[i % 4], seq_a[i % 4], 1, ov, bp, ir, dr);
      else        step(0, 0, 0, 1, ov, bp, ir, dr);
      if (ov) begin
        outs++;
        if (bp) ones++;
      end
    end
    chk("mix_outputs", outs, 16);
    chk("mix_ones", ones, 8);
    chk("mix_acc_remainder", (int'(dut.acc) <= 1) ? 1 : 0, 1);

    // Fill to full with back-pressure, drop one, then drain.
    do_reset();
    for (int i = 0; i < FULL; i++) step(1, 0, 1, 0, ov, bp, ir, dr);
    chk("full_pend", int'(dut.pend), 7);
    chk("full_acc", int'(dut.acc), 14);
    chk("full_in_ready", int'(in_ready), 0);
    step(1, 0, 1, 0, ov, bp, ir, dr);
    chk("full_drop", int'(dr), 1);
    chk("full_drop_in_ready", int'(ir), 0);
    chk("full_after_drop_pend", int'(dut.pend), 7);
    chk("full_after_drop_acc", int'(dut.acc), 14);
    for (int i = 0; i < FULL; i++) begin
      step(0, 0, 0, 1, ov, bp, ir, dr);
      chk("drain_out_valid", int'(ov), 1);
      chk("drain_bipolar", int'(bp), 1);
    end
    #2;
    chk("drain_empty", int'(out_valid), 0);
    chk("drain_acc", int'(dut.acc), 0);

    // Asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 0, 0, (i % 2 == 0), ov, bp, ir, dr);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_pend", int'(dut.pend), 0);
    chk("areset_acc", int'(dut.acc), 0);
    chk("areset_out_valid", int'(out_valid), 0);
    chk("areset_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 0, 0, 1, ov, bp, ir, dr);
    step(1, 0, 0, 1, ov, bp, ir, dr);
    chk("areset_first_valid", int'(ov), 1);
    chk("areset_first_bipolar", int'(bp), 0);

    step(0, 0, 0, 1, ov, bp, ir, dr);
    step(0, 0, 0, 1, ov, bp, ir, dr);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
